sudoku_game_seq: RTL and testbench

SUDOKU_GAME_SEQ -- requirements
Module: sudoku_game_seq

---
 rtl/sudoku_pkg.sv | 37 +++
 rtl/sudoku_conflict_scan.sv | 59 +++++
 rtl/sudoku_game_seq.sv | 146 ++++++++++++++
 tb/tb_sudoku_game_seq.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sudoku_pkg.sv
// Shared constants and helpers for the sudoku game sequencer.
package sudoku_pkg;

  localparam int CELLS        = 81;
  localparam int DIM          = 9;
  localparam int PUZZLE_CELLS = 81;

  // State encodings are visible on the state output, so they stay fixed values.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_WIN   = 3'd4;

  // Scan counter runs 0..81: cells 0..80 are addressed, the last step drains the read pipe.
  localparam logic [6:0] LAST_CELL = 7'd80;
  localparam logic [6:0] SCAN_END  = 7'd81;

  function automatic logic [8:0] puzzle_base(input logic [1:0] sel);
    return 9'(sel) * 9'(PUZZLE_CELLS);
  endfunction

  function automatic logic [6:0] cell_index(input logic [3:0] row, input logic [3:0] col);
    return {3'b000, row} * 7'd9 + {3'b000, col};
  endfunction

  function automatic logic [3:0] third(input logic [3:0] v);
    if (v >= 4'd6)      return 4'd2;
    else if (v >= 4'd3) return 4'd1;
    else                return 4'd0;
  endfunction

  function automatic logic [3:0] box_of(input logic [3:0] row, input logic [3:0] col);
    return third(row) * 4'd3 + third(col);
  endfunction

endpackage

// File: rtl/sudoku_conflict_scan.sv
// Row/column/box duplicate and empty-cell detector, fed one cell per cycle in index order.
module sudoku_conflict_scan
  import sudoku_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic       i_en,
  input  logic [3:0] i_digit,
  output logic       o_bad
);

  logic [8:0] r_row_seen [DIM];
  logic [8:0] r_col_seen [DIM];
  logic [8:0] r_box_seen [DIM];
  logic [3:0] r_row;
  logic [3:0] r_col;
  logic       r_bad;

  logic [3:0] w_box;
  logic [8:0] w_bit;
  logic       w_hit;

  // One-hot digit and hit test; o_bad already includes the cell presented this cycle.
  always_comb begin
    w_box = box_of(r_row, r_col);
    w_bit = '0;
    if (i_digit >= 4'd1 && i_digit <= 4'd9) w_bit = 9'd1 << (i_digit - 4'd1);
    w_hit = (w_bit == '0) ||
            (|(w_bit & (r_row_seen[r_row] | r_col_seen[r_col] | r_box_seen[w_box])));
    o_bad = r_bad | (i_en & w_hit);
  end

  // Seen masks and cell position, cleared when a new scan begins.
  always_ff @(posedge clk) begin
    if (!rst_n || i_start) begin
      for (int unsigned i = 0; i < DIM; i++) begin
        r_row_seen[i] <= '0;
        r_col_seen[i] <= '0;
        r_box_seen[i] <= '0;
      end
      r_row <= '0;
      r_col <= '0;
      r_bad <= 1'b0;
    end else if (i_en) begin
      r_row_seen[r_row] <= r_row_seen[r_row] | w_bit;
      r_col_seen[r_col] <= r_col_seen[r_col] | w_bit;
      r_box_seen[w_box] <= r_box_seen[w_box] | w_bit;
      r_bad             <= o_bad;
      if (r_col == 4'd8) begin
        r_col <= '0;
        r_row <= r_row + 4'd1;
      end else begin
        r_col <= r_col + 4'd1;
      end
    end
  end

endmodule

// File: rtl/sudoku_game_seq.sv
// Sudoku game sequencer: puzzle load from ROM, cursor/digit entry, full-board check.
module sudoku_game_seq
  import sudoku_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic [1:0] puzzle_sel,
  output logic [8:0] rom_addr,
  input  logic [4:0] rom_data,
  output logic       brd_we,
  output logic [6:0] brd_addr,
  output logic [4:0] brd_wdata,
  input  logic [4:0] brd_rdata,
  output logic [2:0] state,
  output logic [3:0] cursor_row,
  output logic [3:0] cursor_col,
  output logic       busy,
  output logic       win
);

  logic [2:0]       r_state;
  logic [6:0]       r_cnt;
  logic [8:0]       r_rom_addr;
  logic [CELLS-1:0] r_given;
  logic [3:0]       r_row;
  logic [3:0]       r_col;

  logic [6:0] w_cur_idx;
  logic [6:0] w_load_cell;
  logic       w_play_wr;
  logic       w_scan_en;
  logic       w_bad;
  logic       w_unused_flag;

  assign w_unused_flag = brd_rdata[4];

  sudoku_conflict_scan u_scan (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_play_wr),
    .i_en    (w_scan_en),
    .i_digit (brd_rdata[3:0]),
    .o_bad   (w_bad)
  );

  // Board port: LOAD writes the ROM word one cycle behind its address, PLAY writes the
  // pre-move cursor cell, CHECK only reads.
  always_comb begin
    w_cur_idx   = cell_index(r_row, r_col);
    w_load_cell = r_cnt - 7'd1;
    w_play_wr   = (r_state == ST_PLAY) && !btn_start && digit_valid &&
                  (digit <= 4'd9) && !r_given[w_cur_idx];
    w_scan_en   = (r_state == ST_CHECK) && (r_cnt != '0);
    brd_we      = 1'b0;
    brd_addr    = '0;
    brd_wdata   = '0;
    case (r_state)
      ST_LOAD: if (r_cnt != '0) begin
        brd_we    = 1'b1;
        brd_addr  = w_load_cell;
        brd_wdata = rom_data;
      end
      ST_PLAY: if (w_play_wr) begin
        brd_we    = 1'b1;
        brd_addr  = w_cur_idx;
        brd_wdata = {1'b0, digit};
      end
      ST_CHECK: if (r_cnt <= LAST_CELL) brd_addr = r_cnt;
      default: ;
    endcase
  end

  // Game state, scan counter, ROM address, given mask and cursor.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_rom_addr <= '0;
      r_given    <= '0;
      r_row      <= '0;
      r_col      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (btn_start) begin
          r_state    <= ST_LOAD;
          r_cnt      <= '0;
          r_rom_addr <= puzzle_base(puzzle_sel);
        end
        ST_LOAD: begin
          if (r_cnt != '0) r_given[w_load_cell] <= rom_data[4];
          if (r_cnt == SCAN_END) begin
            r_state <= ST_PLAY;
            r_cnt   <= '0;
            r_row   <= '0;
            r_col   <= '0;
          end else begin
            r_cnt <= r_cnt + 7'd1;
            if (r_cnt < LAST_CELL) r_rom_addr <= r_rom_addr + 9'd1;
          end
        end
        ST_PLAY: begin
          if (btn_start) begin
            r_state    <= ST_LOAD;
            r_cnt      <= '0;
            r_rom_addr <= puzzle_base(puzzle_sel);
          end else begin
            if (w_play_wr) begin
              r_state <= ST_CHECK;
              r_cnt   <= '0;
            end
            // The write above already used the old cursor, so the move applies alongside it.
            if (btn_up)         r_row <= (r_row == 4'd0) ? 4'd8 : r_row - 4'd1;
            else if (btn_down)  r_row <= (r_row == 4'd8) ? 4'd0 : r_row + 4'd1;
            else if (btn_left)  r_col <= (r_col == 4'd0) ? 4'd8 : r_col - 4'd1;
            else if (btn_right) r_col <= (r_col == 4'd8) ? 4'd0 : r_col + 4'd1;
          end
        end
        ST_CHECK: begin
          if (r_cnt == SCAN_END) begin
            r_state <= w_bad ? ST_PLAY : ST_WIN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 7'd1;
          end
        end
        ST_WIN: if (btn_start) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rom_addr   = r_rom_addr;
  assign state      = r_state;
  assign cursor_row = r_row;
  assign cursor_col = r_col;
  assign busy       = (r_state == ST_LOAD) || (r_state == ST_CHECK);
  assign win        = (r_state == ST_WIN);

endmodule

// File: tb/tb_sudoku_game_seq.sv
// Randomized scoreboard bench for sudoku_game_seq with a ROM/RAM model and a board-level game model.
module tb_sudoku_game_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_start, btn_up, btn_down, btn_left, btn_right, digit_valid;
  logic [3:0] digit;
  logic [1:0] puzzle_sel;
  logic [8:0] rom_addr;
  logic [4:0] rom_data;
  logic       brd_we;
  logic [6:0] brd_addr;
  logic [4:0] brd_wdata, brd_rdata;
  logic [2:0] state;
  logic [3:0] cursor_row, cursor_col;
  logic       busy, win;

  int total = 0;
  int bad   = 0;

  logic [4:0]  rom [512];
  logic [4:0]  ram [128];
  logic [11:0] exp_q [$];

  int m_row, m_col;
  int m_board [81];
  bit m_given [81];
  int sol [81];
  int empty_cell;

  always #5 clk = ~clk;

  sudoku_game_seq dut (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_up(btn_up), .btn_down(btn_down),
    .btn_left(btn_left), .btn_right(btn_right), .digit_valid(digit_valid), .digit(digit),
    .puzzle_sel(puzzle_sel), .rom_addr(rom_addr), .rom_data(rom_data), .brd_we(brd_we),
    .brd_addr(brd_addr), .brd_wdata(brd_wdata), .brd_rdata(brd_rdata), .state(state),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .busy(busy), .win(win)
  );

  // Synchronous puzzle ROM and board RAM, one cycle read latency.
  always @(posedge clk) begin
    rom_data <= rom[rom_addr];
    if (brd_we) ram[brd_addr] <= brd_wdata;
    brd_rdata <= ram[brd_addr];
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every board write is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (brd_we === 1'b1) begin
      chk("we_in_load_or_play", int'(state == 3'd1 || state == 3'd2), 1);
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", int'(brd_addr), -1);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", int'(brd_addr), int'(e[11:5]));
        chk("wr_data", int'(brd_wdata), int'(e[4:0]));
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached, total=%0d", total);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    btn_start = 0; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    digit_valid = 0; digit = 4'd0;
  endtask

  task automatic junk(input bit with_start);
    btn_start   = with_start && ($urandom_range(0, 3) == 0);
    btn_up      = ($urandom_range(0, 3) == 0);
    btn_down    = ($urandom_range(0, 3) == 0);
    btn_left    = ($urandom_range(0, 3) == 0);
    btn_right   = ($urandom_range(0, 3) == 0);
    digit_valid = ($urandom_range(0, 2) == 0);
    digit       = 4'($urandom_range(0, 15));
  endtask

  task automatic chk_cursor(input string n);
    chk({n, "_row"}, int'(cursor_row), m_row);
    chk({n, "_col"}, int'(cursor_col), m_col);
  endtask

  function automatic bit board_ok();
    for (int u = 0; u < 9; u++) begin
      bit [9:0] rs, cs, bs;
      rs = '0; cs = '0; bs = '0;
      for (int v = 0; v < 9; v++) begin
        int a, b, c;
        a = m_board[u * 9 + v];
        b = m_board[v * 9 + u];
        c = m_board[((u / 3) * 3 + v / 3) * 9 + (u % 3) * 3 + v % 3];
        if (a == 0 || b == 0 || c == 0) return 0;
        if (rs[a] || cs[b] || bs[c]) return 0;
        rs[a] = 1; cs[b] = 1; bs[c] = 1;
      end
    end
    return 1;
  endfunction

  task automatic do_reset_check(input string n);
    rst_n = 0;
    tick();
    rst_n = 1;
    chk({n, "_state"}, int'(state), 0);
    chk({n, "_busy"}, int'(busy), 0);
    chk({n, "_win"}, int'(win), 0);
    chk({n, "_we"}, int'(brd_we), 0);
    m_row = 0; m_col = 0;
    chk_cursor(n);
    exp_q.delete();
  endtask

  task automatic do_load(input int sel, input int abort_at);
    int base;
    base = sel * 81;
    puzzle_sel = 2'(sel);
    btn_start = 1;
    for (int k = 0; k < 81; k++) exp_q.push_back({7'(k), rom[base + k]});
    tick();
    clr_in();
    for (int k = 0; k < 82; k++) begin
      if (k == abort_at) begin
        do_reset_check("load_rst");
        return;
      end
      chk("load_state", int'(state), 1);
      chk("load_busy", int'(busy), 1);
      if (k <= 80) chk("rom_addr", int'(rom_addr), base + k);
      junk(1);
      puzzle_sel = 2'($urandom_range(0, 3));
      tick();
      clr_in();
    end
    for (int k = 0; k < 81; k++) begin
      m_board[k] = int'(rom[base + k][3:0]);
      m_given[k] = rom[base + k][4];
    end
    m_row = 0; m_col = 0;
    chk("load_end_state", int'(state), 2);
    chk("load_end_busy", int'(busy), 0);
    chk_cursor("load_end");
  endtask

  task automatic run_check(input int reset_at);
    bit ok;
    ok = board_ok();
    for (int c = 0; c < 82; c++) begin
      if (c == reset_at) begin
        do_reset_check("check_rst");
        return;
      end
      chk("check_state", int'(state), 3);
      chk("check_busy", int'(busy), 1);
      junk(1);
      tick();
      clr_in();
    end
    chk("check_end_state", int'(state), ok ? 4 : 2);
    chk("check_end_win", int'(win), int'(ok));
    chk_cursor("check_end");
  endtask

  task automatic play_cycle(input bit u, input bit d, input bit l, input bit r,
                            input bit dv, input int dg, input int rst_at);
    int idx;
    bit wr;
    idx = m_row * 9 + m_col;
    wr  = dv && dg <= 9 && !m_given[idx];
    btn_up = u; btn_down = d; btn_left = l; btn_right = r;
    digit_valid = dv; digit = 4'(dg);
    if (wr) begin
      exp_q.push_back({7'(idx), 5'(dg)});
      m_board[idx] = dg;
    end
    if (u)      m_row = (m_row + 8) % 9;
    else if (d) m_row = (m_row + 1) % 9;
    else if (l) m_col = (m_col + 8) % 9;
    else if (r) m_col = (m_col + 1) % 9;
    tick();
    clr_in();
    if (wr) begin
      run_check(rst_at);
    end else begin
      chk("play_state", int'(state), 2);
      chk_cursor("play");
    end
  endtask

  task automatic goto_cell(input int idx);
    for (int i = 0; i < 9 && m_row != idx / 9; i++) play_cycle(0, 1, 0, 0, 0, 0, -1);
    for (int i = 0; i < 9 && m_col != idx % 9; i++) play_cycle(0, 0, 0, 1, 0, 0, -1);
  endtask

  task automatic random_play(input int n);
    for (int i = 0; i < n; i++) begin
      bit u, d, l, r, dv;
      int dg;
      u  = ($urandom_range(0, 2) == 0);
      d  = ($urandom_range(0, 2) == 0);
      l  = ($urandom_range(0, 2) == 0);
      r  = ($urandom_range(0, 2) == 0);
      dv = ($urandom_range(0, 3) == 0);
      dg = $urandom_range(0, 15);
      play_cycle(u, d, l, r, dv, dg, -1);
    end
  endtask

  initial begin
    int g, wrong;
    clr_in();
    puzzle_sel = 2'd0;
    rst_n = 0;

    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        sol[r * 9 + c] = ((r * 3 + r / 3 + c) % 9) + 1;
    empty_cell = $urandom_range(0, 80);
    for (int i = 0; i < 512; i++) rom[i] = 5'd0;
    for (int i = 0; i < 128; i++) ram[i] = 5'd0;
    for (int p = 0; p < 4; p++)
      for (int k = 0; k < 81; k++) begin
        if (p == 1)
          rom[81 + k] = (k == empty_cell) ? 5'd0 : {1'b1, 4'(sol[k])};
        else if ($urandom_range(0, 1) == 1)
          rom[p * 81 + k] = {1'b1, 4'($urandom_range(1, 9))};
        else
          rom[p * 81 + k] = 5'd0;
      end

    // Reset values
    repeat (3) tick();
    chk("rst_state", int'(state), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_win", int'(win), 0);
    chk("rst_we", int'(brd_we), 0);
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_brd_addr", int'(brd_addr), 0);
    chk("rst_brd_wdata", int'(brd_wdata), 0);
    m_row = 0; m_col = 0;
    chk_cursor("rst");
    rst_n = 1;

    // IDLE ignores everything but start
    for (int i = 0; i < 6; i++) begin
      junk(0);
      tick();
      clr_in();
      chk("idle_state", int'(state), 0);
      chk_cursor("idle");
    end

    // Load puzzle 2, then cursor wrap sequence
    do_load(2, -1);
    play_cycle(1, 0, 0, 0, 0, 0, -1);
    chk("wrap_up_row", int'(cursor_row), 8);
    play_cycle(0, 0, 1, 0, 0, 0, -1);
    chk("wrap_left_col", int'(cursor_col), 8);
    play_cycle(1, 0, 0, 1, 0, 0, -1);
    chk("up_over_right_row", int'(cursor_row), 7);
    chk("up_over_right_col", int'(cursor_col), 8);
    random_play(150);

    // Near-complete puzzle 1, loaded from PLAY
    do_load(1, -1);
    g = (empty_cell + 1) % 81;
    goto_cell(g);
    play_cycle(0, 0, 0, 0, 1, 5, -1);
    goto_cell(empty_cell);
    play_cycle(0, 0, 0, 0, 1, 12, -1);
    wrong = (sol[empty_cell] == 5) ? 6 : 5;
    play_cycle(0, 0, 0, 0, 1, wrong, -1);
    chk("dup_win", int'(win), 0);
    play_cycle(0, 0, 0, 0, 1, 0, -1);
    play_cycle(0, 0, 0, 0, 1, sol[empty_cell], -1);
    chk("valid_win", int'(win), 1);
    btn_start = 1;
    tick();
    clr_in();
    chk("win_start_state", int'(state), 0);
    chk("win_start_win", int'(win), 0);

    // Reset in the middle of CHECK
    do_load(1, -1);
    goto_cell(empty_cell);
    play_cycle(0, 0, 0, 0, 1, sol[empty_cell], 40);

    // Reset in the middle of LOAD
    do_load(0, 30);

    do_load(3, -1);
    random_play(60);
    do_load(2, -1);
    random_play(40);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
